// File: rtl/sync_fifo_dp.sv
// Synchronous FIFO on an internal dual-port register file with a registered read port,
// occupancy count, almost-full/almost-empty thresholds, error pulses and synchronous flush.
module sync_fifo_dp #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = (2**ADDR_W) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AFULL  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] LP_AEMPTY = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_mem_we;

  // Requests are accepted in the cycle they are presented; there is no ready output.
  // A write into a full FIFO is accepted only when a read frees a slot on the same edge,
  // and an empty FIFO never bypasses write data to the read port.
  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);
  assign w_mem_we = rst_n && !flush && w_wr_acc;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      // On full-and-both the read sees the stored word, since the write lands at this edge.
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + (ADDR_W+1)'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - (ADDR_W+1)'(1);
      end
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= wr_en && !w_wr_acc;
      r_underflow <= rd_en && !w_rd_acc;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_dp.sv
// Directed bench for sync_fifo_dp: default 16x16 instance plus two parameter variants
// driven with random push/pop against a queue model.
module tb_sync_fifo_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit x 16-deep instance
  logic        flush, wr_en, rd_en;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;

  // 16-bit x 4-deep instance, AFULL_TH = 3, AEMPTY_TH = 1
  logic        s1_flush, s1_wr_en, s1_rd_en;
  logic [15:0] s1_wr_data, s1_rd_data;
  logic        s1_rd_valid, s1_full, s1_empty, s1_afull, s1_aempty, s1_ovf, s1_unf;
  logic [2:0]  s1_count;

  // 24-bit x 256-deep instance, default thresholds (254 / 2)
  logic        s2_flush, s2_wr_en, s2_rd_en;
  logic [23:0] s2_wr_data, s2_rd_data;
  logic        s2_rd_valid, s2_full, s2_empty, s2_afull, s2_aempty, s2_ovf, s2_unf;
  logic [8:0]  s2_count;

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_dp u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_dp #(.DATA_W(16), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(s1_flush), .wr_en(s1_wr_en), .wr_data(s1_wr_data),
    .rd_en(s1_rd_en), .rd_data(s1_rd_data), .rd_valid(s1_rd_valid), .full(s1_full),
    .empty(s1_empty), .almost_full(s1_afull), .almost_empty(s1_aempty), .count(s1_count),
    .overflow(s1_ovf), .underflow(s1_unf)
  );

  sync_fifo_dp #(.DATA_W(24), .ADDR_W(8)) u_big (
    .clk(clk), .rst_n(rst_n), .flush(s2_flush), .wr_en(s2_wr_en), .wr_data(s2_wr_data),
    .rd_en(s2_rd_en), .rd_data(s2_rd_data), .rd_valid(s2_rd_valid), .full(s2_full),
    .empty(s2_empty), .almost_full(s2_afull), .almost_empty(s2_aempty), .count(s2_count),
    .overflow(s2_ovf), .underflow(s2_unf)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flag vector order: {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow}
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (count !== 5'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", count);
    end
    n_cmp++;
    if (rd_data !== 16'h0000) begin
      n_err++; $display("FAIL reset_rd_data: got %h want 0000", rd_data);
    end
    n_cmp++;
    if ({full, empty, almost_full, almost_empty, rd_valid, overflow, underflow} !== 7'b0101000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0101000",
               {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow});
    end
    n_cmp++;
    if ({s1_empty, s1_aempty, s1_full, s1_count} !== 6'b110000 ||
        {s2_empty, s2_aempty, s2_full, s2_count} !== 12'b110000000000) begin
      n_err++; $display("FAIL reset_variants: got small %b%b%b/%0d big %b%b%b/%0d want 110/0",
                        s1_empty, s1_aempty, s1_full, s1_count, s2_empty, s2_aempty, s2_full, s2_count);
    end
  endtask

  task automatic test_fill();
    logic [6:0] exp_f;
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 16'(i);
      step();
      exp_f = {i == 16, 1'b0, i >= 14, i <= 2, 3'b000};
      n_cmp++;
      if (count !== 5'(i)) begin
        n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i);
      end
      n_cmp++;
      if ({full, empty, almost_full, almost_empty, rd_valid, overflow, underflow} !== exp_f) begin
        n_err++; $display("FAIL fill_flags[%0d]: got %b want %b", i,
                          {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow}, exp_f);
      end
    end
    wr_data = 16'h0011;
    step();
    n_cmp++;
    if ({count, overflow, full} !== {5'd16, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL fill_overflow: got count=%0d ovf=%b full=%b want 16/1/1", count, overflow, full);
    end
    wr_en = 1'b0;
    step();
    n_cmp++;
    if ({count, overflow} !== {5'd16, 1'b0}) begin
      n_err++; $display("FAIL fill_overflow_clear: got count=%0d ovf=%b want 16/0", count, overflow);
    end
  endtask

  task automatic test_drain();
    logic [6:0] exp_f;
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      exp_f = {1'b0, i == 16, (16 - i) >= 14, (16 - i) <= 2, 3'b100};
      n_cmp++;
      if (rd_data !== 16'(i)) begin
        n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, 16'(i));
      end
      n_cmp++;
      if (count !== 5'(16 - i)) begin
        n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 16 - i);
      end
      n_cmp++;
      if ({full, empty, almost_full, almost_empty, rd_valid, overflow, underflow} !== exp_f) begin
        n_err++; $display("FAIL drain_flags[%0d]: got %b want %b", i,
                          {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow}, exp_f);
      end
    end
    step();
    n_cmp++;
    if ({underflow, rd_valid, rd_data, count} !== {1'b1, 1'b0, 16'h0010, 5'd0}) begin
      n_err++; $display("FAIL drain_underflow: got unf=%b vld=%b data=%h count=%0d want 1/0/0010/0",
                        underflow, rd_valid, rd_data, count);
    end
    rd_en = 1'b0;
    step();
    n_cmp++;
    if ({underflow, rd_data} !== {1'b0, 16'h0010}) begin
      n_err++; $display("FAIL drain_underflow_clear: got unf=%b data=%h want 0/0010", underflow, rd_data);
    end
  endtask

  task automatic test_wrap();
    wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_data = 16'(16'h0100 + k);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = 16'(16'h0103 + k);
      step();
      n_cmp++;
      if ({count, rd_valid, rd_data} !== {5'd3, 1'b1, 16'(16'h0100 + k)}) begin
        n_err++; $display("FAIL wrap_stream[%0d]: got count=%0d vld=%b data=%h want 3/1/%h",
                          k, count, rd_valid, rd_data, 16'(16'h0100 + k));
      end
    end
    wr_en = 1'b0;
    for (int k = 40; k < 43; k++) begin
      step();
      n_cmp++;
      if ({rd_valid, rd_data} !== {1'b1, 16'(16'h0100 + k)}) begin
        n_err++; $display("FAIL wrap_tail[%0d]: got vld=%b data=%h want 1/%h", k, rd_valid, rd_data,
                          16'(16'h0100 + k));
      end
    end
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_simul_empty();
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 16'hBEEF;
    step();
    n_cmp++;
    if ({underflow, overflow, rd_valid, count, rd_data} !== {3'b100, 5'd1, 16'h012A}) begin
      n_err++; $display("FAIL simul_empty: got unf=%b ovf=%b vld=%b count=%0d data=%h want 1/0/0/1/012a",
                        underflow, overflow, rd_valid, count, rd_data);
    end
    wr_en = 1'b0;
    step();
    n_cmp++;
    if ({rd_valid, rd_data, underflow, count} !== {1'b1, 16'hBEEF, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL simul_empty_read: got vld=%b data=%h unf=%b count=%0d want 1/beef/0/0",
                        rd_valid, rd_data, underflow, count);
    end
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_simul_full();
    logic [15:0] exp_d;
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 16'(16'h0200 + i);
      step();
    end
    rd_en = 1'b1;
    wr_data = 16'h02FF;
    step();
    n_cmp++;
    if ({count, full, overflow, rd_valid, rd_data} !== {5'd16, 1'b1, 1'b0, 1'b1, 16'h0200}) begin
      n_err++; $display("FAIL simul_full: got count=%0d full=%b ovf=%b vld=%b data=%h want 16/1/0/1/0200",
                        count, full, overflow, rd_valid, rd_data);
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      exp_d = (i < 16) ? 16'(16'h0200 + i) : 16'h02FF;
      step();
      n_cmp++;
      if ({rd_valid, rd_data} !== {1'b1, exp_d}) begin
        n_err++; $display("FAIL simul_full_drain[%0d]: got vld=%b data=%h want 1/%h", i, rd_valid, rd_data, exp_d);
      end
    end
    rd_en = 1'b0;
    step();
    n_cmp++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL simul_full_empty: got empty=%b count=%0d want 1/0", empty, count);
    end
  endtask

  task automatic test_flush();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'(16'h0300 + i);
      step();
    end
    n_cmp++;
    if (count !== 5'd5) begin
      n_err++; $display("FAIL flush_preload: got %0d want 5", count);
    end
    flush = 1'b1;
    rd_en = 1'b1;
    wr_data = 16'hDEAD;
    step();
    n_cmp++;
    if ({count, empty, rd_valid, overflow, underflow, rd_data} !== {5'd0, 4'b1000, 16'h02FF}) begin
      n_err++; $display("FAIL flush_clear: got count=%0d empty=%b vld=%b ovf=%b unf=%b data=%h want 0/1/0/0/0/02ff",
                        count, empty, rd_valid, overflow, underflow, rd_data);
    end
    flush = 1'b0;
    rd_en = 1'b0;
    wr_data = 16'h1234;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    n_cmp++;
    if ({rd_valid, rd_data, count} !== {1'b1, 16'h1234, 5'd0}) begin
      n_err++; $display("FAIL flush_reuse: got vld=%b data=%h count=%0d want 1/1234/0", rd_valid, rd_data, count);
    end
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_midstream_clear();
    wr_en = 1'b1;
    wr_data = 16'h0400;
    step();
    wr_data = 16'h0401;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    flush = 1'b1;
    step();
    n_cmp++;
    if ({rd_valid, count, rd_data} !== {1'b0, 5'd0, 16'h0400}) begin
      n_err++; $display("FAIL midstream_flush: got vld=%b count=%0d data=%h want 0/0/0400", rd_valid, count, rd_data);
    end
    flush = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b1;
    wr_data = 16'h0500;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({rd_valid, count, rd_data, empty} !== {1'b0, 5'd0, 16'h0000, 1'b1}) begin
      n_err++; $display("FAIL midstream_reset: got vld=%b count=%0d data=%h empty=%b want 0/0/0000/1",
                        rd_valid, count, rd_data, empty);
    end
    rst_n = 1'b1;
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    logic [15:0] exp_q1[$];
    logic [23:0] exp_q2[$];
    logic [15:0] e_d1 = 16'h0000;
    logic [23:0] e_d2 = 24'h000000;
    logic [6:0]  f1, f2;
    bit          r1, w1, r2, w2;
    int          n1, n2, wp, rp;
    for (int cyc = 0; cyc < 800; cyc++) begin
      wp = (cyc < 400) ? 90 : 20;
      rp = (cyc < 400) ? 20 : 90;
      s1_wr_en   = ($urandom_range(99) < wp);
      s1_rd_en   = ($urandom_range(99) < rp);
      s1_wr_data = 16'($urandom);
      s2_wr_en   = ($urandom_range(99) < wp);
      s2_rd_en   = ($urandom_range(99) < rp);
      s2_wr_data = 24'($urandom);
      n1 = exp_q1.size();
      r1 = s1_rd_en && (n1 > 0);
      w1 = s1_wr_en && (n1 < 4 || r1);
      n2 = exp_q2.size();
      r2 = s2_rd_en && (n2 > 0);
      w2 = s2_wr_en && (n2 < 256 || r2);
      if (r1) e_d1 = exp_q1.pop_front();
      if (w1) exp_q1.push_back(s1_wr_data);
      if (r2) e_d2 = exp_q2.pop_front();
      if (w2) exp_q2.push_back(s2_wr_data);
      n1 = exp_q1.size();
      n2 = exp_q2.size();
      f1 = {n1 == 4, n1 == 0, n1 >= 3, n1 <= 1, r1, s1_wr_en && !w1, s1_rd_en && !r1};
      f2 = {n2 == 256, n2 == 0, n2 >= 254, n2 <= 2, r2, s2_wr_en && !w2, s2_rd_en && !r2};
      step();
      n_cmp++;
      if ({s1_count, s1_rd_data} !== {3'(n1), e_d1}) begin
        n_err++; $display("FAIL sweep_small_data[%0d]: got count=%0d data=%h want %0d/%h",
                          cyc, s1_count, s1_rd_data, n1, e_d1);
      end
      n_cmp++;
      if ({s1_full, s1_empty, s1_afull, s1_aempty, s1_rd_valid, s1_ovf, s1_unf} !== f1) begin
        n_err++; $display("FAIL sweep_small_flags[%0d]: got %b want %b", cyc,
                          {s1_full, s1_empty, s1_afull, s1_aempty, s1_rd_valid, s1_ovf, s1_unf}, f1);
      end
      n_cmp++;
      if ({s2_count, s2_rd_data} !== {9'(n2), e_d2}) begin
        n_err++; $display("FAIL sweep_big_data[%0d]: got count=%0d data=%h want %0d/%h",
                          cyc, s2_count, s2_rd_data, n2, e_d2);
      end
      n_cmp++;
      if ({s2_full, s2_empty, s2_afull, s2_aempty, s2_rd_valid, s2_ovf, s2_unf} !== f2) begin
        n_err++; $display("FAIL sweep_big_flags[%0d]: got %b want %b", cyc,
                          {s2_full, s2_empty, s2_afull, s2_aempty, s2_rd_valid, s2_ovf, s2_unf}, f2);
      end
    end
    s1_wr_en = 1'b0;
    s1_rd_en = 1'b0;
    s2_wr_en = 1'b0;
    s2_rd_en = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    s1_flush = 1'b0; s1_wr_en = 1'b0; s1_rd_en = 1'b0; s1_wr_data = '0;
    s2_flush = 1'b0; s2_wr_en = 1'b0; s2_rd_en = 1'b0; s2_wr_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_empty();
    test_simul_full();
    test_flush();
    test_midstream_clear();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_dp.md
# sync_fifo_dp

Parametrised synchronous FIFO built on an internal dual-port register-file RAM. It replaces the asynchronous, tri-stated dual-port RAM plus external pointer logic in the filter datapaths with a single clocked block. The block provides one write port, one registered read port, occupancy count, programmable almost-full/almost-empty thresholds, error pulses and a synchronous flush. It sits between sample producers (ADC/decimator stages) and the Chebyshev filter core.

## Interface
- DATA_W, 16, data word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (legal ADDR_W 2..10)
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH (legal 1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (legal 0..DEPTH-1)

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- flush  in  1  synchronous clear of FIFO state, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data, sampled with wr_en
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data updated this cycle (one-cycle pulse per accepted read)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- State: wr_ptr, rd_ptr (ADDR_W bits each, natural wrap DEPTH-1 -> 0), count register, memory array DEPTH x DATA_W with no reset.
- Write accept: wr_acc = wr_en && (!full || rd_acc). On wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en && !empty. On rd_acc, rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid = 1 next cycle.
- count next: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Empty with rd_en and wr_en together: the write is accepted and the read is rejected. underflow pulses and count becomes 1. There is no write-to-read bypass.
- Full with rd_en and wr_en together: both are accepted. count stays DEPTH and there is no overflow.
- Full with wr_en only: the write is rejected, overflow pulses, and memory and pointers are unchanged.
- Empty with rd_en only: the read is rejected, underflow pulses, and rd_data holds its value.
- The same address is never read and written in one cycle except in the full-and-both case. In that case the read returns the old (stored) word.
- Flags are combinational decodes of the count register, so they reflect state after the last edge. Thresholds are compared unsigned.
- flush (when rst_n = 1):
  - Next edge: wr_ptr, rd_ptr and count go to 0, and rd_valid, overflow and underflow go to 0.
  - rd_data holds its value and the memory is not cleared.
  - flush has priority over wr_en and rd_en in the same cycle; both requests are ignored and raise no error pulse.
- rst_n low at an edge: same as flush, and additionally rd_data goes to 0. rst_n has priority over flush.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (AFULL_TH == 0 ? 1 : 0) (0 for legal values), overflow = 0, underflow = 0.
- Read latency: rd_en high at edge N with FIFO non-empty gives rd_data and rd_valid = 1 after edge N. They are valid throughout cycle N+1.
- Write-to-read latency: a word written at edge N makes empty = 0 after edge N. The earliest accepted read is at edge N+1, and its data appears after edge N+1.
- Flags, count and error pulses update on the same edge as the accepting or rejecting event. Error pulses last exactly one cycle per offending request.
- Sustained throughput: one write and one read per cycle when 0 < count < DEPTH.
- Reset or flush taking effect mid-stream: a read accepted in the previous cycle still shows rd_valid = 0 after the clearing edge. Data from that read is not presented.

## Test plan
- Reset/flags: hold rst_n = 0 for 2 cycles, release -> empty = 1, count = 0, rd_data = 0, almost_empty = 1, all pulses 0.
- Fill/drain (DATA_W = 16, ADDR_W = 4):
  - Write 0x0001..0x0010 -> full = 1 and count = 16. almost_full first rises when count reaches 14.
  - A 17th write -> overflow pulses once and count stays 16.
  - Read 16 times -> rd_data is 0x0001..0x0010 in order, each one cycle after its rd_en. A 17th read -> underflow pulses and rd_data stays 0x0010.
- Wrap-around: stream 40 words with wr_en = rd_en = 1 after pre-loading 3 words -> count stays 3 and output order is preserved across pointer wrap.
- Simultaneous edge cases:
  - Empty with rd_en = wr_en = 1 and wr_data = 0xBEEF -> underflow pulses, count = 1, and the next read returns 0xBEEF.
  - Full with both high -> count stays 16 and there is no overflow.
- Flush: load 5 words, assert flush together with wr_en and rd_en -> count = 0, empty = 1, no pulses, and rd_data unchanged. After that, writing 0x1234 and reading it returns 0x1234.
- Parameter sweep: ADDR_W = 2 with AFULL_TH = 3 and AEMPTY_TH = 1, and ADDR_W = 8 with DATA_W = 24 -> run random push/pop against a scoreboard model, with flags and count matching every cycle.
